// File: rtl/uno_pkg.sv
// Shared UNO card encoding, special card codes and the hand cursor state type.
package uno_pkg;

  localparam int CARD_W    = 6;
  localparam int COLOR_MSB = 5;
  localparam int COLOR_LSB = 4;
  localparam int VALUE_MSB = 3;
  localparam int VALUE_LSB = 0;

  localparam logic [3:0] WILD_COLOR = 4'hE;
  localparam logic [3:0] WILD_DRAW4 = 4'hD;

  localparam logic [CARD_W-1:0] EMPTY_CARD     = 6'h3F;
  localparam logic [CARD_W-1:0] DRAW_SLOT_CARD = 6'h0F;

  typedef enum logic [1:0] {
    HC_IDLE     = 2'd0,
    HC_PLAY_REQ = 2'd1,
    HC_DRAW_REQ = 2'd2
  } hc_state_t;

endpackage

// File: rtl/card_match.sv
// Combinational legality check of one card against the discard pile and active colour.
module card_match #(
  parameter int CARD_W = uno_pkg::CARD_W
) (
  input  logic [CARD_W-1:0] i_card,
  input  logic [CARD_W-1:0] i_prev,
  input  logic [1:0]        i_cur_color,
  output logic              o_playable
);
  import uno_pkg::*;

  logic [3:0] card_value;
  logic [3:0] prev_value;
  logic [1:0] card_color;
  logic       is_wild;

  always_comb begin
    card_value = i_card[VALUE_MSB:VALUE_LSB];
    prev_value = i_prev[VALUE_MSB:VALUE_LSB];
    card_color = i_card[COLOR_MSB:COLOR_LSB];
    is_wild    = (card_value == WILD_COLOR) || (card_value == WILD_DRAW4);
    o_playable = is_wild || (card_color == i_cur_color) || (card_value == prev_value);
  end

endmodule

// File: rtl/hand_cursor.sv
// Cursor over the packed hand plus a trailing DRAW slot; turns select into play/draw requests.
// Handshake: a request's valid stays high with a stable payload until ready; transfer on valid && ready.
module hand_cursor #(
  parameter int HAND_DEPTH = 108,
  parameter int CARD_W     = 6,
  parameter int IDX_W      = $clog2(HAND_DEPTH + 1),
  parameter bit WRAP       = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_left,
  input  logic                i_right,
  input  logic                i_select,
  input  logic [IDX_W-1:0]    i_hand_num,
  input  logic [CARD_W-1:0]   i_hand_card,
  input  logic [CARD_W-1:0]   i_prev_card,
  input  logic [1:0]          i_cur_color,
  output logic [IDX_W-1:0]    o_index,
  output logic                o_play_valid,
  input  logic                i_play_ready,
  output logic [CARD_W-1:0]   o_play_card,
  output logic [IDX_W-1:0]    o_play_index,
  output logic                o_draw_valid,
  input  logic                i_draw_ready,
  output logic                o_illegal,
  output logic                o_busy,
  output uno_pkg::hc_state_t  o_state
);
  import uno_pkg::*;

  localparam logic [IDX_W-1:0] DRAW_IDX = IDX_W'(HAND_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  hc_state_t         state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  pidx_q, pidx_d;
  logic [CARD_W-1:0] card_q, card_d;
  logic              play_valid_q, play_valid_d;
  logic              draw_valid_q, draw_valid_d;
  logic              illegal_q, illegal_d;
  logic              busy_q, busy_d;

  logic              playable;
  logic              on_draw;
  logic              hand_empty;
  logic              need_clamp;
  logic              go_left;
  logic              go_right;
  logic [IDX_W-1:0]  last_idx;

  card_match #(.CARD_W(CARD_W)) u_card_match (
    .i_card      (i_hand_card),
    .i_prev      (i_prev_card),
    .i_cur_color (i_cur_color),
    .o_playable  (playable)
  );

  always_comb begin
    on_draw    = (idx_q == DRAW_IDX);
    hand_empty = (i_hand_num == IDX_ZERO);
    last_idx   = i_hand_num - IDX_ONE;
    // The hand can shrink under the cursor; pull it back onto a real card first.
    need_clamp = !on_draw && (idx_q >= i_hand_num);
    go_right   = i_enable && i_right && !i_left;
    go_left    = i_enable && i_left && !i_right;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pidx_d    = pidx_q;
    card_d    = card_q;
    illegal_d = 1'b0;
    case (state_q)
      HC_IDLE: begin
        if (need_clamp) begin
          idx_d = hand_empty ? DRAW_IDX : last_idx;
        end else if (i_enable && i_select) begin
          if (on_draw) begin
            state_d = HC_DRAW_REQ;
          end else if (playable) begin
            state_d = HC_PLAY_REQ;
            card_d  = i_hand_card;
            pidx_d  = idx_q;
          end else begin
            illegal_d = 1'b1;
          end
        end else if (go_right) begin
          if (on_draw) begin
            idx_d = (WRAP && !hand_empty) ? IDX_ZERO : DRAW_IDX;
          end else if (idx_q == last_idx) begin
            idx_d = DRAW_IDX;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else if (go_left) begin
          if (on_draw) begin
            idx_d = hand_empty ? DRAW_IDX : last_idx;
          end else if (idx_q == IDX_ZERO) begin
            idx_d = WRAP ? DRAW_IDX : IDX_ZERO;
          end else begin
            idx_d = idx_q - IDX_ONE;
          end
        end
      end
      HC_PLAY_REQ: if (i_play_ready) state_d = HC_IDLE;
      HC_DRAW_REQ: if (i_draw_ready) state_d = HC_IDLE;
      default:     state_d = HC_IDLE;
    endcase
    play_valid_d = (state_d == HC_PLAY_REQ);
    draw_valid_d = (state_d == HC_DRAW_REQ);
    busy_d       = (state_d != HC_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= HC_IDLE;
      idx_q        <= '0;
      pidx_q       <= '0;
      card_q       <= '0;
      play_valid_q <= 1'b0;
      draw_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pidx_q       <= pidx_d;
      card_q       <= card_d;
      play_valid_q <= play_valid_d;
      draw_valid_q <= draw_valid_d;
      illegal_q    <= illegal_d;
      busy_q       <= busy_d;
    end
  end

  assign o_index      = idx_q;
  assign o_play_index = pidx_q;
  assign o_play_card  = card_q;
  assign o_play_valid = play_valid_q;
  assign o_draw_valid = draw_valid_q;
  assign o_illegal    = illegal_q;
  assign o_busy       = busy_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_hand_cursor.sv
// Bench for hand_cursor: a wrapping and a saturating instance share stimulus, each with its own model.
module tb_hand_cursor;

  localparam int DRAW = 108;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       left = 1'b0, right = 1'b0, select = 1'b0;
  logic [6:0] hand_num = 7'd3;
  logic [5:0] prev_card = 6'h00;
  logic [1:0] cur_color = 2'd0;
  logic       play_ready = 1'b0, draw_ready = 1'b0;
  logic [5:0] hand [0:108];

  logic [6:0] idx_a, idx_b, pidx_a, pidx_b;
  logic [5:0] card_a, card_b, hcard_a, hcard_b;
  logic       pv_a, pv_b, dv_a, dv_b, ill_a, ill_b, busy_a, busy_b;
  uno_pkg::hc_state_t st_a, st_b;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int idx;
    int st;
    int card;
    int pidx;
    bit ill;
  } model_t;

  model_t ma, mb;

  assign hcard_a = (idx_a == 7'd108) ? 6'h0F : hand[idx_a];
  assign hcard_b = (idx_b == 7'd108) ? 6'h0F : hand[idx_b];

  hand_cursor #(.HAND_DEPTH(108), .CARD_W(6), .WRAP(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_left(left), .i_right(right),
    .i_select(select), .i_hand_num(hand_num), .i_hand_card(hcard_a),
    .i_prev_card(prev_card), .i_cur_color(cur_color), .o_index(idx_a),
    .o_play_valid(pv_a), .i_play_ready(play_ready), .o_play_card(card_a),
    .o_play_index(pidx_a), .o_draw_valid(dv_a), .i_draw_ready(draw_ready),
    .o_illegal(ill_a), .o_busy(busy_a), .o_state(st_a)
  );

  hand_cursor #(.HAND_DEPTH(108), .CARD_W(6), .WRAP(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_left(left), .i_right(right),
    .i_select(select), .i_hand_num(hand_num), .i_hand_card(hcard_b),
    .i_prev_card(prev_card), .i_cur_color(cur_color), .o_index(idx_b),
    .o_play_valid(pv_b), .i_play_ready(play_ready), .o_play_card(card_b),
    .o_play_index(pidx_b), .o_draw_valid(dv_b), .i_draw_ready(draw_ready),
    .o_illegal(ill_b), .o_busy(busy_b), .o_state(st_b)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cursor is a position on a ring of n+1 slots, the last being DRAW.
  function automatic model_t model_reset();
    model_t r;
    r.idx = 0; r.st = 0; r.card = 0; r.pidx = 0; r.ill = 0;
    return r;
  endfunction

  function automatic bit legal(input int c);
    int v, col;
    v = c % 16;
    col = (c / 16) % 4;
    return (v == 13) || (v == 14) || (col == int'(cur_color)) || (v == int'(prev_card) % 16);
  endfunction

  function automatic model_t step(input model_t m, input bit wrap);
    model_t r;
    int n, p;
    r = m;
    n = int'(hand_num);
    r.ill = 0;
    if (m.st == 0) begin
      if (m.idx != DRAW && m.idx >= n) begin
        r.idx = (n == 0) ? DRAW : n - 1;
      end else if (enable && select) begin
        if (m.idx == DRAW) r.st = 2;
        else if (legal(int'(hand[m.idx]))) begin
          r.st = 1; r.card = int'(hand[m.idx]); r.pidx = m.idx;
        end else r.ill = 1;
      end else if (enable && (left != right)) begin
        p = (m.idx == DRAW) ? n : m.idx;
        if (right) p = wrap ? (p + 1) % (n + 1) : ((p + 1 > n) ? n : p + 1);
        else       p = wrap ? (p + n) % (n + 1) : ((p == 0) ? 0 : p - 1);
        r.idx = (p == n) ? DRAW : p;
      end
    end else if (m.st == 1) begin
      if (play_ready) r.st = 0;
    end else begin
      if (draw_ready) r.st = 0;
    end
    return r;
  endfunction

  // Scoreboard comparisons against both models
  task automatic compare_all();
    check("a.idx",   32'(idx_a),  32'(ma.idx));
    check("a.pv",    32'(pv_a),   32'(ma.st == 1));
    check("a.dv",    32'(dv_a),   32'(ma.st == 2));
    check("a.busy",  32'(busy_a), 32'(ma.st != 0));
    check("a.ill",   32'(ill_a),  32'(ma.ill));
    check("a.card",  32'(card_a), 32'(ma.card));
    check("a.pidx",  32'(pidx_a), 32'(ma.pidx));
    check("b.idx",   32'(idx_b),  32'(mb.idx));
    check("b.pv",    32'(pv_b),   32'(mb.st == 1));
    check("b.dv",    32'(dv_b),   32'(mb.st == 2));
    check("b.busy",  32'(busy_b), 32'(mb.st != 0));
    check("b.ill",   32'(ill_b),  32'(mb.ill));
    check("b.card",  32'(card_b), 32'(mb.card));
    check("b.pidx",  32'(pidx_b), 32'(mb.pidx));
  endtask

  // Driver tasks
  task automatic cycle();
    model_t na, nb;
    na = step(ma, 1'b1);
    nb = step(mb, 1'b0);
    @(posedge clk);
    #1;
    if (rst) begin
      ma = model_reset();
      mb = model_reset();
    end else begin
      ma = na;
      mb = nb;
    end
    compare_all();
  endtask

  task automatic keys(input bit l, input bit r, input bit s);
    left = l; right = r; select = s;
    cycle();
    left = 1'b0; right = 1'b0; select = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    hand_num = 7'(n);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    ma = model_reset();
    mb = model_reset();
    compare_all();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 109; i++) hand[i] = 6'h00;
    ma = model_reset();
    mb = model_reset();

    // Navigation, wrap and saturation
    do_reset(3);
    check("rst.idx", 32'(idx_a), 32'd0);
    check("rst.busy", 32'(busy_a), 32'd0);
    keys(0, 1, 0); check("t1.r1", 32'(idx_a), 32'd1);
    keys(0, 1, 0); check("t1.r2", 32'(idx_a), 32'd2);
    keys(0, 1, 0); check("t1.r3", 32'(idx_a), 32'd108);
    keys(0, 1, 0); check("t1.r4", 32'(idx_a), 32'd0);
                   check("t2.sat_hi", 32'(idx_b), 32'd108);
    keys(1, 0, 0); check("t1.l1", 32'(idx_a), 32'd108);
    do_reset(3);
    keys(1, 0, 0); check("t2.l0", 32'(idx_b), 32'd0);
    keys(0, 1, 0); check("t2.r1", 32'(idx_b), 32'd1);
    keys(0, 1, 0); check("t2.r2", 32'(idx_b), 32'd2);
    keys(0, 1, 0); check("t2.r3", 32'(idx_b), 32'd108);
    keys(0, 1, 0); check("t2.r4", 32'(idx_b), 32'd108);

    // Legal play with backpressure
    do_reset(3);
    hand[0] = 6'h21; hand[1] = 6'h13; hand[2] = 6'h0E;
    cur_color = 2'd2; prev_card = 6'h25;
    keys(0, 0, 1);
    check("t3.pv", 32'(pv_a), 32'd1);
    check("t3.card", 32'(card_a), 32'h21);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3.hold", 32'(card_a), 32'h21);
    end
    play_ready = 1'b1; cycle(); play_ready = 1'b0;
    check("t3.drop", 32'(pv_a), 32'd0);

    // Illegal and wild
    keys(0, 1, 0);
    keys(0, 0, 1);
    check("t4.ill", 32'(ill_a), 32'd1);
    check("t4.nopv", 32'(pv_a), 32'd0);
    cycle();
    check("t4.ill_end", 32'(ill_a), 32'd0);
    keys(0, 1, 0);
    keys(0, 0, 1);
    check("t4.wild", 32'(card_a), 32'h0E);
    check("t4.wpidx", 32'(pidx_a), 32'd2);
    play_ready = 1'b1; cycle(); play_ready = 1'b0;

    // Draw request and clamp
    keys(0, 1, 0);
    keys(0, 0, 1);
    check("t5.dv", 32'(dv_a), 32'd1);
    for (int i = 0; i < 3; i++) cycle();
    draw_ready = 1'b1; cycle(); draw_ready = 1'b0;
    check("t5.dv_end", 32'(dv_a), 32'd0);
    do_reset(5);
    for (int i = 0; i < 4; i++) keys(0, 1, 0);
    check("t5.at4", 32'(idx_a), 32'd4);
    hand_num = 7'd4; cycle();
    check("t5.clamp", 32'(idx_a), 32'd3);
    hand_num = 7'd0; cycle();
    check("t5.empty", 32'(idx_a), 32'd108);

    // Corner cases
    do_reset(3);
    keys(1, 1, 0); check("t6.lr", 32'(idx_a), 32'd0);
    enable = 1'b0;
    keys(0, 1, 0); check("t6.dis_r", 32'(idx_a), 32'd0);
    keys(0, 0, 1); check("t6.dis_s", 32'(pv_a), 32'd0);
    enable = 1'b1;
    keys(0, 1, 1);
    check("t6.sr_pv", 32'(pv_a), 32'd1);
    check("t6.sr_idx", 32'(idx_a), 32'd0);
    enable = 1'b0; cycle(); enable = 1'b1;
    check("t6.hold_dis", 32'(pv_a), 32'd1);
    async_reset();
    check("t6.rst_pv", 32'(pv_a), 32'd0);
    check("t6.rst_card", 32'(card_a), 32'd0);

    // Randomized phase
    for (int i = 0; i < 109; i++) hand[i] = 6'($urandom_range(0, 63));
    hand_num = 7'($urandom_range(0, 8));
    for (int c = 0; c < 3000; c++) begin
      enable     = ($urandom_range(0, 9) != 0);
      left       = ($urandom_range(0, 3) == 0);
      right      = ($urandom_range(0, 3) == 0);
      select     = ($urandom_range(0, 7) == 0);
      play_ready = ($urandom_range(0, 2) == 0);
      draw_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) cur_color = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) prev_card = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0)
        hand_num = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 108)) : 7'($urandom_range(0, 8));
      if ($urandom_range(0, 299) == 0) async_reset();
      else cycle();
    end
    left = 1'b0; right = 1'b0; select = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hand_cursor.md
# hand_cursor

Parametrised cursor-and-play controller for the human player's UNO hand. It walks an index over the packed hand plus a trailing DRAW slot, driven by debounced key pulses, and checks the highlighted card against the discard pile. It then issues a play or draw request to the game engine over a valid/ready handshake. It sits between the Debounce instances and the game FSM, and its `o_index` also feeds the VGA Display and hex readout.

## Interface

**Parameters**
- `HAND_DEPTH`, default 108: maximum cards held. Slot `HAND_DEPTH` is the DRAW position.
- `CARD_W`, default 6: card code width. Bits [5:4] are colour, bits [3:0] are value.
- `IDX_W`, default `$clog2(HAND_DEPTH+1)`: index width.
- `WRAP`, default 1: 1 = cursor ring wraps; 0 = cursor saturates at both ends.

**Ports**
- `i_clk` in, 1: system clock (1 MHz domain).
- `i_rst` in, 1: reset. Asynchronous, active-high.
- `i_enable` in, 1: player's turn. When 0, key pulses are ignored.
- `i_left`, `i_right`, `i_select` in, 1 each: single-cycle debounced key pulses.
- `i_hand_num` in, IDX_W: number of valid cards. Cards are packed at indices 0..n-1.
- `i_hand_card` in, CARD_W: card at `o_index`, read combinationally by the owner of the hand array.
- `i_prev_card` in, CARD_W: top of discard pile.
- `i_cur_color` in, 2: active colour (differs from `i_prev_card[5:4]` after a wild).
- `o_index` out, IDX_W: cursor position.
- `o_play_valid` out, 1: play request.
- `i_play_ready` in, 1: engine accepts the play.
- `o_play_card` out, CARD_W: card being played.
- `o_play_index` out, IDX_W: index of the card being played.
- `o_draw_valid` out, 1: draw request.
- `i_draw_ready` in, 1: engine accepts the draw.
- `o_illegal` out, 1: one-cycle pulse when an unplayable card is selected.
- `o_busy` out, 1: a request is outstanding.

## Operation

**Cursor ring order:** 0, 1, …, n−1, DRAW, where n = `i_hand_num`.
- **Right:** idx → idx+1. From n−1 → DRAW. From DRAW → 0 (WRAP=1) or stay (WRAP=0).
- **Left:** idx → idx−1. From 0 → DRAW (WRAP=1) or stay (WRAP=0). From DRAW → n−1.
- **n = 0:** cursor is forced to DRAW, and left/right leave it there.

**Clamp:** in IDLE, if `o_index` < DRAW and `o_index` ≥ n, the next `o_index` = n−1 (or DRAW if n = 0). Clamp has priority over navigation in the same cycle.

**Playability**, evaluated on `i_hand_card`:
- value 13 or 14 (wild): always playable;
- else colour == `i_cur_color`: playable;
- else value == `i_prev_card[3:0]`: playable.

**FSM states:** IDLE, PLAY_REQ, DRAW_REQ.
- **IDLE:** acts on key pulses only while `i_enable` = 1. `i_select` has priority over left/right. Left and right asserted together with no select: no move.
- **IDLE + select with cursor on DRAW:** go to DRAW_REQ.
- **IDLE + select on a playable card:** latch `o_play_card` and `o_play_index`, go to PLAY_REQ.
- **IDLE + select on an unplayable card:** pulse `o_illegal` for one cycle, stay in IDLE.
- **PLAY_REQ:** `o_play_valid` = 1. On `i_play_ready`, go to IDLE. Keys are ignored.
- **DRAW_REQ:** `o_draw_valid` = 1. On `i_draw_ready`, go to IDLE. Keys are ignored.
- Once raised, a request holds with stable payload until ready, even if `i_enable` falls.

`o_busy` = 1 in PLAY_REQ or DRAW_REQ.

## Timing

- **Reset values:** `o_index` = 0, state = IDLE, all valids = 0, `o_illegal` = 0, `o_busy` = 0, payloads = 0. Reset may assert mid-request and aborts the request immediately.
- **Outputs:** all registered.
- **Latency:** key pulse at edge t → `o_index`, valid or `o_illegal` updates at t+1.
- **Handshake:** transfer occurs on the edge where valid && ready. Valid drops the following cycle. Ready while valid = 0 is ignored.
- **Clamp after a play:** if `i_hand_num` drops in the cycle after acceptance, clamp occurs one cycle after IDLE is re-entered.
- **Width rules:** index arithmetic is done in IDX_W bits with no overflow past DRAW.

## Structure

- Shared `uno_pkg` holds:
  - `CARD_W`, `COLOR_MSB/LSB`, `VALUE_MSB/LSB`;
  - constants `WILD_COLOR` = 4'hE, `WILD_DRAW4` = 4'hD, `EMPTY_CARD` = 6'h3F, `DRAW_SLOT_CARD` = 6'h0F;
  - the `hc_state_t` enum.
- One combinational sub-module, `card_match` (card, prev, cur_color → playable), reused later by the computer-player AI.
- The rest is a single cursor/FSM module.

## Test plan

1. **Navigation and wrap:** reset, n = 3, WRAP=1. Right ×4 → `o_index` 1, 2, 108, 0. Left ×1 → 108.
2. **Saturation:** WRAP=0, n = 3, index 0. Left → stays 0. Right ×3 → 1, 2, 108. Right → stays 108.
3. **Legal play:** `i_cur_color` = 2, prev = 6'h25, card = 6'h21, select → `o_play_valid` = 1 next cycle with card 6'h21. Hold `i_play_ready` low 5 cycles → payload stable. Ready → valid = 0 next cycle.
4. **Illegal and wild:** same prev/colour, card 6'h13, select → `o_illegal` pulse for 1 cycle, no valid. Card 6'h0E → play request issued.
5. **Draw and clamp:** cursor on DRAW, select → `o_draw_valid` until `i_draw_ready`. With index 4 and n dropping 5 → 4: `o_index` = 3. With n = 0: `o_index` = 108.
6. **Corner cases:** left+right in the same cycle → no move. Select+right → request only. `i_enable` = 0 → keys ignored. `i_rst` during PLAY_REQ → all outputs return to reset values asynchronously.
